mux_sel_sequencer: RTL and testbench
====================================

# mux_sel_sequencer

Generates the 2-bit select for the 4-to-1 selector stage downstream: a pushbutton-driven, debounced select stepper with an optional auto-scan mode. Takes a raw board pushbutton and two slide switches, produces `sel[1:0]` wired directly to the mux select, and a one-hot copy for LED indication. Single clock domain; all board inputs are treated as asynchronous and synchronized internally.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized samples required to accept a button level change (10 ms at 50 MHz); minimum 2.
- `SCAN_CYCLES`, 25000000: clock cycles between automatic advances in auto mode; minimum 2.
- `clk`  in  1  system clock (50 MHz board clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `step_n`  in  1  raw pushbutton, active-low (pressed = 0), asynchronous.
- `mode`  in  1  slide switch: 0 = manual stepping, 1 = auto scan; asynchronous.
- `dir`  in  1  slide switch: 0 = count up, 1 = count down; asynchronous.
- `sel`  out  2  select to the 4-to-1 mux.
- `sel_onehot`  out  4  one-hot of `sel` (bit n high when `sel` = n), for LEDs.
- `advance`  out  1  one-cycle pulse, high in the first cycle `sel` holds a new value.
- `running`  out  1  high in AUTO_RUN state only.

## Operation
- Synchronizers: `step_n`, `mode`, `dir` each pass through a 2-flop synchronizer; only synchronized values are used below.
- Debounce: registered level `db` (reset 1). Counter increments each cycle synchronized `step_n` differs from `db`, clears to 0 whenever they match. On the cycle the counter is at `DEBOUNCE_CYCLES-1` and still differs, `db` takes the new value and counter clears.
- Press event: `db` 1->0 transition; one cycle wide. Release (0->1) generates no event.
- Step: `sel` <= `sel`+1 if `dir`=0, `sel`-1 if `dir`=1, modulo 4 (3->0 up, 0->3 down). `dir` sampled at the step cycle.
- FSM states: MANUAL, AUTO_RUN, AUTO_HOLD. Reset state MANUAL.
  - MANUAL: press -> step. `mode`=1 -> AUTO_RUN, scan counter cleared.
  - AUTO_RUN: scan counter counts 0..`SCAN_CYCLES-1`; at terminal count -> step, counter to 0. Press -> AUTO_HOLD, counter cleared, no step (press wins over simultaneous terminal count). `mode`=0 -> MANUAL.
  - AUTO_HOLD: counter held at 0, no steps. Press -> AUTO_RUN. `mode`=0 -> MANUAL.
  - `mode`=0 has priority over a press in the same cycle in either AUTO state; that press is discarded.
- `sel` is never modified by state transitions themselves; only by steps.
- `sel_onehot` is a registered/derived function of `sel`, always consistent with it in the same cycle.

## Timing
- Reset values: `sel`=0, `sel_onehot`=4'b0001, `advance`=0, `running`=0, `db`=1, all counters 0, synchronizer flops 1 for `step_n`, 0 for `mode`/`dir`.
- Press latency: `step_n` first sampled low at edge k -> `db` falls at edge k+1+`DEBOUNCE_CYCLES` -> `sel` updates and `advance` rises at edge k+2+`DEBOUNCE_CYCLES`.
- Glitch rejection: any low pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- Auto scan: with `running`=1 continuously, `advance` pulses exactly every `SCAN_CYCLES` cycles; first pulse `SCAN_CYCLES` cycles after entering AUTO_RUN.
- `mode` change latency: 2 synchronizer cycles + 1 state update.
- `running` asserted the cycle after the FSM enters AUTO_RUN decision edge (registered with state).
- Reset asserted mid-debounce or mid-scan: all state returns to reset values immediately; no `advance` on reset release.
- Held button: one step per press, none while held, none on release.

## Test plan
- Params `DEBOUNCE_CYCLES`=4, `SCAN_CYCLES`=8 for all scenarios.
- Reset then `mode`=0, `dir`=0, four clean presses (low 10 cycles, high 10) -> `sel` 1,2,3,0; `advance` 4 single-cycle pulses; `sel_onehot` 0010,0100,1000,0001.
- `dir`=1 from `sel`=0, one press -> `sel`=3 at edge k+6 after first low sample; bounce pulses of 1-3 cycles low -> no change.
- `mode`=1 -> `running`=1, `advance` every 8 cycles, `sel` 0,1,2,3,0; press -> `running`=0, `sel` frozen 40 cycles; press -> resumes, next advance 8 cycles later.
- Press event coincident with scan terminal count -> AUTO_HOLD, `sel` unchanged, no `advance`.
- `rst_n` low for 1 cycle mid-scan with `sel`=2 -> `sel`=0, `running`=0, state MANUAL despite `mode`=1 until resynchronized, then AUTO_RUN with first advance 8 cycles later.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Debounced pushbutton select stepper with an optional auto-scan mode.
// Drives the 2-bit select of a downstream 4-to-1 mux, plus a one-hot copy
// of that select for LED indication.
// There is no valid/ready handshake on this block. 'advance' is a plain
// one-cycle strobe that is high in the first cycle 'sel' holds a new value.
// Consumers may sample 'sel' at any time, because it only changes on a step.

module mux_sel_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCAN_CYCLES     = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_n,
    input  logic       mode,
    input  logic       dir,
    output logic [1:0] sel,
    output logic [3:0] sel_onehot,
    output logic       advance,
    output logic       running,
    output logic [1:0] state_dbg
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

    localparam logic [1:0] ST_MANUAL    = 2'd0;
    localparam logic [1:0] ST_AUTO_RUN  = 2'd1;
    localparam logic [1:0] ST_AUTO_HOLD = 2'd2;

    // Two-flop synchronizers. Bit 1 is the synchronized value.
    logic [1:0]      step_sync_q, step_sync_d;
    logic [1:0]      mode_sync_q, mode_sync_d;
    logic [1:0]      dir_sync_q,  dir_sync_d;
    logic            step_s, mode_s, dir_s;

    logic            db_q, db_d;
    logic            db_prev_q, db_prev_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press;

    logic [1:0]      state_q, state_d;
    logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
    logic            do_step;

    logic [1:0]      sel_q, sel_d;
    logic [3:0]      onehot_q, onehot_d;
    logic            advance_q, advance_d;
    logic            running_q, running_d;

    assign step_s = step_sync_q[1];
    assign mode_s = mode_sync_q[1];
    assign dir_s  = dir_sync_q[1];

    // Next value of every synchronizer stage: shift in the raw board input.
    always_comb begin
        step_sync_d = {step_sync_q[0], step_n};
        mode_sync_d = {mode_sync_q[0], mode};
        dir_sync_d  = {dir_sync_q[0], dir};
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
    always_comb begin
        db_d      = db_q;
        db_cnt_d  = '0;
        db_prev_d = db_q;
        if (step_s != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = step_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    // A press is the cycle right after the debounced level falls. A release makes no event.
    assign press = db_prev_q & ~db_q;

    // Mode FSM and scan timer. A low mode switch overrides a press in either auto state.
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        do_step    = 1'b0;
        case (state_q)
            ST_MANUAL: begin
                do_step = press;
                if (mode_s) begin
                    state_d    = ST_AUTO_RUN;
                    scan_cnt_d = '0;
                end
            end
            ST_AUTO_RUN: begin
                if (!mode_s) begin
                    state_d    = ST_MANUAL;
                    scan_cnt_d = '0;
                end else if (press) begin
                    state_d    = ST_AUTO_HOLD;
                    scan_cnt_d = '0;
                end else if (scan_cnt_q == SC_LAST) begin
                    do_step    = 1'b1;
                    scan_cnt_d = '0;
                end else begin
                    scan_cnt_d = scan_cnt_q + SC_ONE;
                end
            end
            ST_AUTO_HOLD: begin
                scan_cnt_d = '0;
                if (!mode_s) begin
                    state_d = ST_MANUAL;
                end else if (press) begin
                    state_d = ST_AUTO_RUN;
                end
            end
            default: begin
                state_d    = ST_MANUAL;
                scan_cnt_d = '0;
            end
        endcase
    end

    // Select stepping (modulo 4 by 2-bit wrap) and the registered status outputs.
    always_comb begin
        sel_d = sel_q;
        if (do_step) begin
            sel_d = dir_s ? (sel_q - 2'd1) : (sel_q + 2'd1);
        end
        onehot_d  = 4'b0001 << sel_d;
        advance_d = do_step;
        running_d = (state_d == ST_AUTO_RUN);
    end

    // All state registers. Asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync_q <= 2'b11;
            mode_sync_q <= 2'b00;
            dir_sync_q  <= 2'b00;
            db_q        <= 1'b1;
            db_prev_q   <= 1'b1;
            db_cnt_q    <= '0;
            state_q     <= ST_MANUAL;
            scan_cnt_q  <= '0;
            sel_q       <= 2'd0;
            onehot_q    <= 4'b0001;
            advance_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            step_sync_q <= step_sync_d;
            mode_sync_q <= mode_sync_d;
            dir_sync_q  <= dir_sync_d;
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            sel_q       <= sel_d;
            onehot_q    <= onehot_d;
            advance_q   <= advance_d;
            running_q   <= running_d;
        end
    end

    assign sel        = sel_q;
    assign sel_onehot = onehot_q;
    assign advance    = advance_q;
    assign running    = running_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Testbench for mux_sel_sequencer.
// Table-driven presses, hand-written multi-cycle corner sequences, and a
// randomized phase. A behavioural reference model checks every cycle.

module tb_mux_sel_sequencer;

    localparam int D = 4;
    localparam int S = 8;

    // ---------------- clock / reset / DUT ----------------
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       step_n = 1'b1;
    logic       mode   = 1'b0;
    logic       dir    = 1'b0;
    logic [1:0] sel;
    logic [3:0] sel_onehot;
    logic       advance;
    logic       running;
    logic [1:0] state_dbg;

    int total   = 0;
    int bad     = 0;
    int adv_cnt = 0;

    logic [1:0] exp_q[$];

    mux_sel_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .SCAN_CYCLES    (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_n    (step_n),
        .mode      (mode),
        .dir       (dir),
        .sel       (sel),
        .sel_onehot(sel_onehot),
        .advance   (advance),
        .running   (running),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum {M_MANUAL, M_RUN, M_HOLD} m_state_t;

    bit       sq[$];
    bit       mq[$];
    bit       dq[$];
    bit       m_db;
    bit       m_press;
    int       m_run;
    int       m_scan;
    m_state_t m_st;
    int       m_sel;
    bit       m_adv;

    function automatic void model_reset();
        sq      = '{1'b1, 1'b1};
        mq      = '{1'b0, 1'b0};
        dq      = '{1'b0, 1'b0};
        m_db    = 1'b1;
        m_press = 1'b0;
        m_run   = 0;
        m_scan  = 0;
        m_st    = M_MANUAL;
        m_sel   = 0;
        m_adv   = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using pre-edge values.
    function automatic void model_edge(input bit raw_s, input bit raw_m, input bit raw_d);
        bit s2;
        bit m2;
        bit d2;
        bit stepping;
        bit fell;
        s2       = sq[0];
        m2       = mq[0];
        d2       = dq[0];
        stepping = 1'b0;
        fell     = 1'b0;
        case (m_st)
            M_MANUAL: begin
                if (m_press) stepping = 1'b1;
                if (m2) begin
                    m_st   = M_RUN;
                    m_scan = 0;
                end
            end
            M_RUN: begin
                if (!m2) begin
                    m_st   = M_MANUAL;
                    m_scan = 0;
                end else if (m_press) begin
                    m_st   = M_HOLD;
                    m_scan = 0;
                end else if (m_scan == S - 1) begin
                    stepping = 1'b1;
                    m_scan   = 0;
                end else begin
                    m_scan++;
                end
            end
            default: begin
                if (!m2) m_st = M_MANUAL;
                else if (m_press) begin
                    m_st   = M_RUN;
                    m_scan = 0;
                end
            end
        endcase
        if (stepping) m_sel = (m_sel + (d2 ? 3 : 1)) % 4;
        m_adv = stepping;
        // debounced level flips on the D-th consecutive differing sample
        if (s2 != m_db) begin
            m_run++;
            if (m_run == D) begin
                m_db  = s2;
                m_run = 0;
                fell  = (s2 == 1'b0);
            end
        end else begin
            m_run = 0;
        end
        m_press = fell;
        sq.push_back(raw_s); void'(sq.pop_front());
        mq.push_back(raw_m); void'(mq.pop_front());
        dq.push_back(raw_d); void'(dq.pop_front());
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [3:0] oh;
        oh        = 4'b0000;
        oh[m_sel] = 1'b1;
        chk({tag, "_sel"},     32'(sel),        32'(m_sel));
        chk({tag, "_onehot"},  32'(sel_onehot), 32'(oh));
        chk({tag, "_advance"}, 32'(advance),    32'(m_adv));
        chk({tag, "_running"}, 32'(running),    32'(m_st == M_RUN));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        bit rs;
        bit rm;
        bit rd;
        bit rr;
        rs = step_n;
        rm = mode;
        rd = dir;
        rr = rst_n;
        @(posedge clk);
        if (!rr) model_reset();
        else model_edge(rs, rm, rd);
        #1;
        if (advance === 1'b1) adv_cnt++;
        compare_outputs("model");
    endtask

    task automatic wait_running(input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (running !== val && n < 30);
    endtask

    task automatic wait_adv(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (advance !== 1'b1 && n < 30);
    endtask

    typedef struct {
        logic       dir;
        int         low;
        int         high;
        logic [1:0] exp_sel;
        logic [3:0] exp_oh;
        int         exp_adv;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[7];
        int   n;

        vecs[0] = '{dir: 1'b0, low: 10, high: 10, exp_sel: 2'd1, exp_oh: 4'b0010, exp_adv: 1};
        vecs[1] = '{dir: 1'b0, low: 10, high: 10, exp_sel: 2'd2, exp_oh: 4'b0100, exp_adv: 1};
        vecs[2] = '{dir: 1'b0, low: 10, high: 10, exp_sel: 2'd3, exp_oh: 4'b1000, exp_adv: 1};
        vecs[3] = '{dir: 1'b0, low: 10, high: 10, exp_sel: 2'd0, exp_oh: 4'b0001, exp_adv: 1};
        vecs[4] = '{dir: 1'b1, low: 1,  high: 10, exp_sel: 2'd3, exp_oh: 4'b1000, exp_adv: 0};
        vecs[5] = '{dir: 1'b1, low: 2,  high: 10, exp_sel: 2'd3, exp_oh: 4'b1000, exp_adv: 0};
        vecs[6] = '{dir: 1'b1, low: 3,  high: 10, exp_sel: 2'd3, exp_oh: 4'b1000, exp_adv: 0};

        // reset
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_sel",     32'(sel),        32'd0);
        chk("reset_onehot",  32'(sel_onehot), 32'b0001);
        chk("reset_advance", 32'(advance),    32'd0);
        chk("reset_running", 32'(running),    32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // clean manual presses, counting up
        for (int i = 0; i < 4; i++) begin
            dir     = vecs[i].dir;
            adv_cnt = 0;
            step_n  = 1'b0;
            repeat (vecs[i].low) tick();
            step_n = 1'b1;
            repeat (vecs[i].high) tick();
            chk($sformatf("vec%0d_sel", i),    32'(sel),        32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_onehot", i), 32'(sel_onehot), 32'(vecs[i].exp_oh));
            chk($sformatf("vec%0d_advcnt", i), 32'(adv_cnt),    32'(vecs[i].exp_adv));
        end

        // press latency counting down from 0: sel becomes 3 at edge k+6
        dir = 1'b1;
        repeat (4) tick();
        step_n = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("lat_hold%0d", j), 32'(sel), 32'd0);
        end
        tick();
        chk("lat_sel",     32'(sel),     32'd3);
        chk("lat_advance", 32'(advance), 32'd1);
        step_n = 1'b1;
        repeat (10) tick();

        // short bounce pulses are rejected
        for (int i = 4; i < 7; i++) begin
            dir     = vecs[i].dir;
            adv_cnt = 0;
            step_n  = 1'b0;
            repeat (vecs[i].low) tick();
            step_n = 1'b1;
            repeat (vecs[i].high) tick();
            chk($sformatf("vec%0d_sel", i),    32'(sel),        32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_onehot", i), 32'(sel_onehot), 32'(vecs[i].exp_oh));
            chk($sformatf("vec%0d_advcnt", i), 32'(adv_cnt),    32'(vecs[i].exp_adv));
        end

        // auto scan from sel=3
        dir  = 1'b0;
        mode = 1'b1;
        wait_running(1'b1, n);
        chk("mode_latency", 32'(n), 32'd3);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 4; k++) begin
            wait_adv(n);
            chk($sformatf("scan_gap%0d", k), 32'(n),   32'(S));
            chk($sformatf("scan_sel%0d", k), 32'(sel), 32'(exp_q.pop_front()));
        end

        // press -> hold, frozen for 40 cycles
        step_n = 1'b0;
        wait_running(1'b0, n);
        chk("hold_latency", 32'(n), 32'd7);
        step_n  = 1'b1;
        adv_cnt = 0;
        repeat (40) tick();
        chk("hold_advcnt", 32'(adv_cnt), 32'd0);
        chk("hold_sel",    32'(sel),     32'd3);

        // press -> resume, next advance S cycles later
        step_n = 1'b0;
        wait_running(1'b1, n);
        chk("resume_latency", 32'(n), 32'd7);
        step_n = 1'b1;
        wait_adv(n);
        chk("resume_gap", 32'(n),   32'(S));
        chk("resume_sel", 32'(sel), 32'd0);

        // press event lands on the scan terminal count: hold wins, no step
        adv_cnt = 0;
        tick();
        step_n = 1'b0;
        repeat (7) tick();
        chk("coinc_running", 32'(running), 32'd0);
        chk("coinc_advcnt",  32'(adv_cnt), 32'd0);
        chk("coinc_sel",     32'(sel),     32'd0);
        step_n = 1'b1;
        repeat (12) tick();
        chk("coinc_after_advcnt", 32'(adv_cnt), 32'd0);
        chk("coinc_after_sel",    32'(sel),     32'd0);

        // resume and run to sel=2, then reset mid-scan
        step_n = 1'b0;
        wait_running(1'b1, n);
        chk("resume2_latency", 32'(n), 32'd7);
        step_n = 1'b1;
        wait_adv(n);
        wait_adv(n);
        chk("pre_reset_sel", 32'(sel), 32'd2);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midscan_rst_sel",     32'(sel),        32'd0);
        chk("midscan_rst_onehot",  32'(sel_onehot), 32'b0001);
        chk("midscan_rst_running", 32'(running),    32'd0);
        chk("midscan_rst_advance", 32'(advance),    32'd0);
        tick();
        rst_n = 1'b1;
        wait_running(1'b1, n);
        chk("rst_mode_latency", 32'(n), 32'd3);
        wait_adv(n);
        chk("rst_first_gap", 32'(n),   32'(S));
        chk("rst_first_sel", 32'(sel), 32'd1);

        // randomized stimulus against the model
        for (int seg = 0; seg < 300; seg++) begin
            step_n = ~step_n;
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            dir = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) tick();
        end
        step_n = 1'b1;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL watchdog: actual=timeout required=finish at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
